xor_stream_cipher: RTL



---
 rtl/xor_stream_if.sv | 22 ++
 rtl/xor_stream_cipher.sv | 94 +++++++++
 2 files changed

// File: rtl/xor_stream_if.sv
// Valid/ready record stream into and out of the XOR stream cipher.
// The slave modport is the cipher's view; the master modport is the producer/consumer view.
interface xor_stream_if #(
    parameter int DATA_W = 80
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/xor_stream_cipher.sv
// Single-stage XOR stream cipher for vote records: record ^ MSB-aligned repeated key.
// Define XOR_STREAM_KEY_ROLL_EN to rotate the key left by KEY_ROT after every accepted record.
module xor_stream_cipher #(
    parameter int DATA_W  = 80,
    parameter int KEY_W   = 64,
    parameter int KEY_ROT = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key_in,
    xor_stream_if.slave      stream,
    output logic             keyed,
    output logic [CNT_W-1:0] rec_cnt
);
    localparam int REP = (DATA_W + KEY_W - 1) / KEY_W;

    typedef enum logic {NOKEY, KEYED} state_t;

    state_t            state;
    logic [KEY_W-1:0]  key_p0;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              accept;

    if (KEY_ROT < 0 || KEY_ROT >= KEY_W) begin : g_bad_rot
        $error("KEY_ROT must lie in [0, KEY_W)");
    end

    // Key repeated from the MSB end; the top DATA_W bits of the repetition form the keystream.
    function automatic logic [DATA_W-1:0] keystream(input logic [KEY_W-1:0] k);
        logic [REP*KEY_W-1:0] rep;
        rep = {REP{k}};
        return rep[REP*KEY_W-1 -: DATA_W];
    endfunction

`ifdef XOR_STREAM_KEY_ROLL_EN
    function automatic logic [KEY_W-1:0] rot_left(input logic [KEY_W-1:0] k);
        logic [KEY_W-1:0] r;
        for (int i = 0; i < KEY_W; i++) begin
            r[i] = k[(i + KEY_W - KEY_ROT) % KEY_W];
        end
        return r;
    endfunction
`endif

    assign stream.in_ready  = (state == KEYED) && (!vld_p1 || stream.out_ready);
    assign stream.out_valid = vld_p1;
    assign stream.data_out  = data_p1;
    assign accept           = stream.in_valid && stream.in_ready;

    // Stage p1: registered result; a same-cycle key_load wins over counting and rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= NOKEY;
            keyed   <= 1'b0;
            key_p0  <= '0;
            rec_cnt <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            case (state)
                NOKEY: begin
                    if (key_load) begin
                        state <= KEYED;
                        keyed <= 1'b1;
                    end
                end
                default: begin
                    state <= KEYED;
                    keyed <= 1'b1;
                end
            endcase

            if (key_load) begin
                key_p0  <= key_in;
                rec_cnt <= '0;
            end else if (accept) begin
                rec_cnt <= rec_cnt + 1'b1;
`ifdef XOR_STREAM_KEY_ROLL_EN
                key_p0  <= rot_left(key_p0);
`endif
            end

            if (accept) begin
                data_p1 <= stream.data_in ^ keystream(key_p0);
                vld_p1  <= 1'b1;
            end else if (stream.out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end
endmodule
